// File: rtl/mmc1_serial_writer.sv
// Bus master that loads one MMC1 register through its 5-bit serial port by emitting
// NES CPU write cycles (one data bit per write), optionally preceded by a shift-register reset write.
module mmc1_serial_writer #(
    parameter int M2_LO = 2,
    parameter int M2_HI = 2,
    parameter int GAP   = 1
) (
    input  logic       ck,
    input  logic       nres,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_reg,
    input  logic [4:0] req_data,
    input  logic       req_reset,
    output logic       done,
    output logic       cpu_m2,
    output logic       cpu_rnw,
    output logic       cpu_nromsel,
    output logic [1:0] cpu_a,
    output logic       cpu_d0,
    output logic       cpu_d7
);

    localparam int CYC = M2_LO + M2_HI;
    localparam int PW  = $clog2(CYC);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYC - 1);
    localparam logic [PW-1:0] PH_M2    = PW'(M2_LO);
    localparam logic [1:0]    GAP_LAST = 2'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_RST_WR, S_BIT_WR, S_GAP} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic [1:0]      gap_reg, gap_next;
    logic [2:0]      bit_reg, bit_next;
    logic [1:0]      reg_l_reg, reg_l_next;
    logic [4:0]      data_l_reg, data_l_next;
    logic            m2_reg, m2_next;
    logic            rnw_reg, rnw_next;
    logic            nromsel_reg, nromsel_next;
    logic [1:0]      a_reg, a_next;
    logic            d0_reg, d0_next;
    logic            d7_reg, d7_next;
    logic            done_reg, done_next;
    logic            cyc_end;
    logic [4:0]      data_shift;

    assign cyc_end = (phase_reg == PH_LAST);

    always_comb begin
        state_next  = state_reg;
        phase_next  = cyc_end ? '0 : phase_reg + PW'(1);
        gap_next    = gap_reg;
        bit_next    = bit_reg;
        reg_l_next  = reg_l_reg;
        data_l_next = data_l_reg;

        case (state_reg)
            S_IDLE: begin
                phase_next = '0;
                if (req_valid) begin
                    state_next  = req_reset ? S_RST_WR : S_BIT_WR;
                    bit_next    = 3'd0;
                    reg_l_next  = req_reg;
                    data_l_next = req_data;
                end
            end
            S_RST_WR: begin
                if (cyc_end) begin
                    state_next = S_GAP;
                    gap_next   = 2'd0;
                end
            end
            S_BIT_WR: begin
                if (cyc_end) begin
                    state_next = S_GAP;
                    gap_next   = 2'd0;
                    bit_next   = (bit_reg == 3'd5) ? 3'd5 : bit_reg + 3'd1;
                end
            end
            S_GAP: begin
                if (cyc_end) begin
                    if (gap_reg == GAP_LAST)
                        state_next = (bit_reg >= 3'd5) ? S_IDLE : S_BIT_WR;
                    else
                        gap_next = gap_reg + 2'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs are computed from the upcoming state so they change on the same edge as it.
    assign data_shift = data_l_next >> bit_next;

    always_comb begin
        m2_next      = (state_next != S_IDLE) && (phase_next >= PH_M2);
        rnw_next     = 1'b1;
        nromsel_next = 1'b1;
        a_next       = 2'd0;
        d0_next      = 1'b0;
        d7_next      = 1'b0;
        done_next    = (state_next == S_IDLE) && (state_reg == S_GAP);

        case (state_next)
            S_RST_WR: begin
                rnw_next     = 1'b0;
                nromsel_next = ~m2_next;
                a_next       = reg_l_next;
                d7_next      = 1'b1;
            end
            S_BIT_WR: begin
                rnw_next     = 1'b0;
                nromsel_next = ~m2_next;
                a_next       = reg_l_next;
                d0_next      = data_shift[0];
            end
            S_GAP: begin
                a_next  = a_reg;
                d0_next = d0_reg;
                d7_next = d7_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            gap_reg     <= 2'd0;
            bit_reg     <= 3'd0;
            reg_l_reg   <= 2'd0;
            data_l_reg  <= 5'd0;
            m2_reg      <= 1'b0;
            rnw_reg     <= 1'b1;
            nromsel_reg <= 1'b1;
            a_reg       <= 2'd0;
            d0_reg      <= 1'b0;
            d7_reg      <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            gap_reg     <= gap_next;
            bit_reg     <= bit_next;
            reg_l_reg   <= reg_l_next;
            data_l_reg  <= data_l_next;
            m2_reg      <= m2_next;
            rnw_reg     <= rnw_next;
            nromsel_reg <= nromsel_next;
            a_reg       <= a_next;
            d0_reg      <= d0_next;
            d7_reg      <= d7_next;
            done_reg    <= done_next;
        end
    end

    assign req_ready   = (state_reg == S_IDLE);
    assign done        = done_reg;
    assign cpu_m2      = m2_reg;
    assign cpu_rnw     = rnw_reg;
    assign cpu_nromsel = nromsel_reg;
    assign cpu_a       = a_reg;
    assign cpu_d0      = d0_reg;
    assign cpu_d7      = d7_reg;

endmodule
